// File: rtl/axi4_sram_bridge.sv
// axi4_sram_bridge
// AXI4 slave in front of a dual-port SRAM macro (W0 masked write port, R0 read
// port with one cycle of read latency). Read and write bursts are serialised.
// Every burst is INCR of 64-bit beats, and both directions sustain one beat per cycle.
//
// Ports:
//   clock, reset         sole clock; asynchronous active-high reset
//   aw*/w*/b*            AXI4 write address, write data and write response channels
//   ar*/r*               AXI4 read address and read data channels
//   W0_*                 SRAM write port (clock, word address, enable, data, byte mask)
//   R0_*                 SRAM read port (clock, word address, enable, returned data)
module axi4_sram_bridge #(
    parameter int unsigned ADDR_BITS = 25,
    parameter int unsigned ID_BITS   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [ADDR_BITS+2:0] awaddr,
    input  logic [7:0]           awlen,
    input  logic [ID_BITS-1:0]   awid,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic [63:0]          wdata,
    input  logic [7:0]           wstrb,
    input  logic                 wlast,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [ID_BITS-1:0]   bid,
    output logic [1:0]           bresp,
    input  logic                 arvalid,
    output logic                 arready,
    input  logic [ADDR_BITS+2:0] araddr,
    input  logic [7:0]           arlen,
    input  logic [ID_BITS-1:0]   arid,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [63:0]          rdata,
    output logic [ID_BITS-1:0]   rid,
    output logic [1:0]           rresp,
    output logic                 rlast,
    output logic                 W0_clk,
    output logic [ADDR_BITS-1:0] W0_addr,
    output logic                 W0_en,
    output logic [63:0]          W0_data,
    output logic [7:0]           W0_mask,
    output logic                 R0_clk,
    output logic [ADDR_BITS-1:0] R0_addr,
    output logic                 R0_en,
    input  logic [63:0]          R0_data
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StWresp} state_e;

    state_e               state_q, state_d;
    logic                 prio_q, prio_d;      // 0: read wins a tie, 1: write wins
    logic [ID_BITS-1:0]   id_q, id_d;
    logic [7:0]           len_q, len_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [8:0]           cnt_q, cnt_d;        // beats issued (read) / accepted (write)

    // Read return path: one read may be in flight in the SRAM, its data lands in a
    // 2-entry FIFO unless it can be handed straight to the R channel.
    logic                 inflight_q, inflight_last_q;
    logic [63:0]          fifo_data_q [2];
    logic                 fifo_last_q [2];
    logic                 rd_ptr_q, wr_ptr_q;
    logic [1:0]           count_q;

    logic                 fifo_empty, head_last, deq, push, pop, issue, read_sel;
    logic [2:0]           occ;
    logic                 unused_bits;

    assign unused_bits = ^{awaddr[2:0], araddr[2:0], wlast};

    assign fifo_empty = (count_q == 2'd0);
    assign rvalid     = !fifo_empty || inflight_q;
    // Empty FIFO: the SRAM output is forwarded directly so a read costs two cycles.
    assign rdata      = !fifo_empty ? fifo_data_q[rd_ptr_q] : (inflight_q ? R0_data : '0);
    assign head_last  = !fifo_empty ? fifo_last_q[rd_ptr_q] : inflight_last_q;
    assign rlast      = rvalid && head_last;
    assign rid        = id_q;
    assign rresp      = 2'b00;
    assign bid        = id_q;
    assign bresp      = 2'b00;

    assign deq  = rvalid && rready;
    assign push = inflight_q && !(fifo_empty && deq);
    assign pop  = deq && !fifo_empty;
    // Entries that will still be held next cycle; a new issue needs room for one more.
    assign occ   = 3'(count_q) + 3'(inflight_q) - 3'(deq);
    assign issue = (state_q == StRead) && (cnt_q <= {1'b0, len_q}) && (occ <= 3'd1);

    assign read_sel = arvalid && (!awvalid || !prio_q);

    assign W0_clk  = clock;
    assign R0_clk  = clock;
    assign W0_addr = addr_q;
    assign R0_addr = addr_q;
    assign W0_data = wdata;
    assign W0_mask = wstrb;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        len_d   = len_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        R0_en   = 1'b0;
        W0_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // The tie-break pointer only moves when both requests competed.
                if (read_sel) begin
                    arready = 1'b1;
                    state_d = StRead;
                    id_d    = arid;
                    len_d   = arlen;
                    addr_d  = araddr[ADDR_BITS+2:3];
                    cnt_d   = 9'd0;
                    if (awvalid) prio_d = 1'b1;
                end else if (awvalid) begin
                    awready = 1'b1;
                    state_d = StWrite;
                    id_d    = awid;
                    len_d   = awlen;
                    addr_d  = awaddr[ADDR_BITS+2:3];
                    cnt_d   = 9'd0;
                    if (arvalid) prio_d = 1'b0;
                end
            end
            StRead: begin
                if (issue) begin
                    R0_en  = 1'b1;
                    addr_d = addr_q + ADDR_BITS'(1);
                    cnt_d  = cnt_q + 9'd1;
                end
                if (deq && head_last) state_d = StIdle;
            end
            StWrite: begin
                wready = 1'b1;
                if (wvalid) begin
                    W0_en  = 1'b1;
                    addr_d = addr_q + ADDR_BITS'(1);
                    cnt_d  = cnt_q + 9'd1;
                    // Beat count alone ends the burst; wlast is not consulted.
                    if (cnt_q[7:0] == len_q) state_d = StWresp;
                end
            end
            StWresp: begin
                bvalid = 1'b1;
                if (bready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            prio_q          <= 1'b0;
            id_q            <= '0;
            len_q           <= '0;
            addr_q          <= '0;
            cnt_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            state_q         <= state_d;
            prio_q          <= prio_d;
            id_q            <= id_d;
            len_q           <= len_d;
            addr_q          <= addr_d;
            cnt_q           <= cnt_d;
            inflight_q      <= R0_en;
            inflight_last_q <= R0_en && (cnt_q == {1'b0, len_q});
            if (push) begin
                fifo_data_q[wr_ptr_q] <= R0_data;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= !wr_ptr_q;
            end
            if (pop) rd_ptr_q <= !rd_ptr_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_axi4_sram_bridge.sv
// tb_axi4_sram_bridge
// Randomised and directed bench for axi4_sram_bridge (25-bit word address instance).
// A behavioural SRAM sits on the W0/R0 ports; a separate reference memory plus
// expected-beat queues predict every W0 write, R beat and B response.
module tb_axi4_sram_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [27:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb, W0_mask;
    logic [3:0]  awid, arid, bid, rid;
    logic [63:0] wdata, rdata, W0_data, R0_data;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic        W0_clk, W0_en, R0_clk, R0_en;
    logic [24:0] W0_addr, R0_addr;

    always #5 clock = ~clock;

    axi4_sram_bridge #(.ADDR_BITS(25), .ID_BITS(4)) dut (
        .clock(clock), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp),
        .rlast(rlast),
        .W0_clk(W0_clk), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
        .W0_mask(W0_mask),
        .R0_clk(R0_clk), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
    );

    typedef struct packed { logic [63:0] d; logic [3:0] id; logic last; } rbeat_t;
    typedef struct packed { logic [24:0] a; logic [63:0] d; logic [7:0] m; } wbeat_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          issued = 0;
    int          delivered = 0;
    int          t_ar_hs = 0;
    int          t_aw_hs = 0;
    int          rmode = 0;
    int          bmode = 0;
    int          pidx = 0;
    logic        prio_m = 1'b0;
    logic        stall_prev = 1'b0;
    logic [63:0] prev_d = '0;
    logic        prev_l = 1'b0;
    rbeat_t      exp_r[$];
    wbeat_t      exp_w[$];
    logic [3:0]  exp_b[$];
    logic [24:0] w_log[$];
    logic [63:0] wd_q[$];
    logic [7:0]  ws_q[$];
    logic [63:0] ref_mem [logic [24:0]];
    logic [63:0] sram [1024];

    // Initial SRAM content: a recognisable pattern keyed on the low address bits.
    function automatic logic [63:0] dflt(input logic [24:0] a);
        return 64'hA5A5_0000_0000_0000 ^ {54'd0, a[9:0]};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] ref_rd(input logic [24:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural SRAM: masked write, one-cycle read latency.
    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = dflt(25'(i));
        forever begin
            @(posedge clock);
            if (W0_en) sram[W0_addr[9:0]] = merge(sram[W0_addr[9:0]], W0_data, W0_mask);
            if (R0_en) R0_data <= sram[R0_addr[9:0]];
        end
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Ready generators: 0 = always high, 1 = random, 2 = repeating 1,0,0,1.
    initial begin
        rready = 1'b1;
        bready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (rmode == 0) rready = 1'b1;
            else if (rmode == 1) rready = 1'($urandom_range(0, 1));
            else rready = ((pidx % 4) == 0) || ((pidx % 4) == 3);
            pidx++;
            bready = (bmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Compare process: every cycle outputs are checked against the queues and rules.
    initial forever begin
        @(negedge clock);
        if (reset) begin
            issued = 0;
            delivered = 0;
            prio_m = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk_eq("clk_fwd", {62'd0, W0_clk, R0_clk}, {62'd0, clock, clock});
            chk_eq("en_excl", 64'(R0_en & W0_en), 64'd0);
            if (stall_prev) begin
                chk_eq("r_hold_valid", 64'(rvalid), 64'd1);
                chk_eq("r_hold_data", rdata, prev_d);
                chk_eq("r_hold_last", 64'(rlast), 64'(prev_l));
            end
            stall_prev = rvalid && !rready;
            prev_d = rdata;
            prev_l = rlast;
            if (rvalid) chk_eq("rresp", 64'(rresp), 64'd0);
            if (rvalid && rready) begin
                delivered++;
                chk_eq("r_expected", 64'(exp_r.size() > 0), 64'd1);
                if (exp_r.size() > 0) begin
                    rbeat_t e;
                    e = exp_r.pop_front();
                    chk_eq("rdata", rdata, e.d);
                    chk_eq("rid", 64'(rid), 64'(e.id));
                    chk_eq("rlast", 64'(rlast), 64'(e.last));
                end
            end
            if (R0_en) issued++;
            if (R0_en || rvalid) chk_eq("r_outstanding", 64'((issued - delivered) <= 2), 64'd1);
            if (W0_en) begin
                w_log.push_back(W0_addr);
                chk_eq("w_expected", 64'(exp_w.size() > 0), 64'd1);
                if (exp_w.size() > 0) begin
                    wbeat_t e;
                    e = exp_w.pop_front();
                    chk_eq("W0_addr", 64'(W0_addr), 64'(e.a));
                    chk_eq("W0_data", W0_data, e.d);
                    chk_eq("W0_mask", 64'(W0_mask), 64'(e.m));
                end
            end
            if (bvalid) chk_eq("bresp", 64'(bresp), 64'd0);
            if (bvalid && bready) begin
                chk_eq("b_expected", 64'(exp_b.size() > 0), 64'd1);
                if (exp_b.size() > 0) chk_eq("bid", 64'(bid), 64'(exp_b.pop_front()));
            end
            if (arvalid && awvalid && (arready || awready)) begin
                chk_eq("arb_arready", 64'(arready), 64'(!prio_m));
                chk_eq("arb_awready", 64'(awready), 64'(prio_m));
                prio_m = !prio_m;
            end
        end
    end

    task automatic send_ar(input logic [24:0] word, input int len, input logic [3:0] id);
        bit got = 0;
        araddr  = {word, 3'($urandom_range(0, 7))};
        arlen   = 8'(len);
        arid    = id;
        arvalid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            if (arready) begin
                got = 1;
                break;
            end
        end
        chk_eq("ar_handshake", 64'(got), 64'd1);
        if (got) begin
            t_ar_hs = cyc;
            for (int i = 0; i <= len; i++)
                exp_r.push_back('{d: ref_rd(word + 25'(i)), id: id, last: (i == len)});
        end
        @(posedge clock);
        #1 arvalid = 1'b0;
    endtask

    task automatic wait_rlast();
        bit got = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            if (rvalid && rready && rlast) begin
                got = 1;
                break;
            end
        end
        chk_eq("rlast_seen", 64'(got), 64'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic do_read(input logic [24:0] word, input int len, input logic [3:0] id);
        send_ar(word, len, id);
        wait_rlast();
    endtask

    // Uses wd_q/ws_q as the beat data; predicts W0 writes, memory state and B response.
    task automatic send_aw(input logic [24:0] word, input int len, input logic [3:0] id);
        bit got = 0;
        awaddr  = {word, 3'($urandom_range(0, 7))};
        awlen   = 8'(len);
        awid    = id;
        awvalid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            if (awready) begin
                got = 1;
                break;
            end
        end
        chk_eq("aw_handshake", 64'(got), 64'd1);
        if (got) begin
            t_aw_hs = cyc;
            for (int i = 0; i <= len; i++) begin
                logic [24:0] a;
                a = word + 25'(i);
                exp_w.push_back('{a: a, d: wd_q[i], m: ws_q[i]});
                ref_mem[a] = merge(ref_rd(a), wd_q[i], ws_q[i]);
            end
            exp_b.push_back(id);
        end
        @(posedge clock);
        #1 awvalid = 1'b0;
    endtask

    task automatic do_write(input logic [24:0] word, input int len, input logic [3:0] id,
                            input bit gaps);
        bit got;
        wd_q.delete();
        ws_q.delete();
        for (int i = 0; i <= len; i++) begin
            wd_q.push_back({$urandom, $urandom});
            ws_q.push_back(8'($urandom));
        end
        send_aw(word, len, id);
        for (int i = 0; i <= len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
            wvalid = 1'b1;
            wdata  = wd_q[i];
            wstrb  = ws_q[i];
            wlast  = (i == len);
            got = 0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clock);
                if (wready) begin
                    got = 1;
                    break;
                end
            end
            chk_eq("w_handshake", 64'(got), 64'd1);
            @(posedge clock);
            #1;
            wvalid = 1'b0;
            wlast  = 1'b0;
        end
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (bvalid && bready) begin
                got = 1;
                break;
            end
        end
        chk_eq("b_handshake", 64'(got), 64'd1);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [24:0] rnd_word();
        if ($urandom_range(0, 7) == 0) return 25'h1FFFFF8 + 25'($urandom_range(0, 7));
        return 25'($urandom_range(0, 200));
    endfunction

    initial begin
        int d0;
        awvalid = 0; awaddr = 0; awlen = 0; awid = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
        arvalid = 0; araddr = 0; arlen = 0; arid = 0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_eq("reset_ctrl", 64'({arready, awready, wready, rvalid, bvalid, W0_en, R0_en, rlast}),
               64'd0);
        chk_eq("reset_ids", 64'({rid, bid}), 64'd0);
        chk_eq("reset_rdata", rdata, 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Single-beat write to byte 0x40 (word 8), low four bytes enabled.
        wd_q = '{64'h1122334455667788};
        ws_q = '{8'h0F};
        send_aw(25'd8, 0, 4'd5);
        wvalid = 1'b1; wdata = 64'h1122334455667788; wstrb = 8'h0F; wlast = 1'b1;
        @(negedge clock);
        chk_eq("wr_wready", 64'(wready), 64'd1);
        chk_eq("wr_W0_en", 64'(W0_en), 64'd1);
        chk_eq("wr_W0_addr", 64'(W0_addr), 64'd8);
        chk_eq("wr_W0_mask", 64'(W0_mask), 64'h0F);
        @(posedge clock);
        #1 wvalid = 1'b0; wlast = 1'b0;
        @(negedge clock);
        chk_eq("wr_bvalid", 64'(bvalid), 64'd1);
        chk_eq("wr_bid", 64'(bid), 64'd5);
        @(posedge clock);
        #1;

        // Four-beat read from word 8 with rready high.
        send_ar(25'd8, 3, 4'd9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk_eq("rd_R0_en", 64'(R0_en), 64'd1);
            chk_eq("rd_R0_addr", 64'(R0_addr), 64'(8 + i));
            if (i == 1) begin
                chk_eq("rd_first_rvalid", 64'(rvalid), 64'd1);
                chk_eq("rd_first_rdata", rdata, 64'hA5A50000_55667788);
                chk_eq("rd_first_rid", 64'(rid), 64'd9);
                chk_eq("rd_first_rlast", 64'(rlast), 64'd0);
            end
        end
        wait_rlast();

        // Same read with rready toggling 1,0,0,1.
        d0 = delivered;
        rmode = 2;
        pidx = 0;
        do_read(25'd8, 3, 4'd2);
        chk_eq("toggle_beats", 64'(delivered - d0), 64'd4);
        rmode = 0;

        // Simultaneous AW and AR: read first, then write first on the next pair.
        fork
            do_read(25'h20, 1, 4'd3);
            do_write(25'h30, 1, 4'd4, 1'b0);
        join
        chk_eq("tie1_read_first", 64'(t_ar_hs < t_aw_hs), 64'd1);
        fork
            do_read(25'h30, 1, 4'd1);
            do_write(25'h20, 1, 4'd7, 1'b0);
        join
        chk_eq("tie2_write_first", 64'(t_aw_hs < t_ar_hs), 64'd1);

        // Word address wrap at the top of the 25-bit space.
        w_log.delete();
        do_write(25'h1FFFFFE, 2, 4'd6, 1'b0);
        chk_eq("wrap_count", 64'(w_log.size()), 64'd3);
        if (w_log.size() == 3) begin
            chk_eq("wrap_a0", 64'(w_log[0]), 64'h1FFFFFE);
            chk_eq("wrap_a1", 64'(w_log[1]), 64'h1FFFFFF);
            chk_eq("wrap_a2", 64'(w_log[2]), 64'h0000000);
        end
        do_read(25'h1FFFFFF, 1, 4'd7);

        // Randomised traffic.
        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 2);
            rmode = $urandom_range(0, 1);
            bmode = $urandom_range(0, 1);
            case (op)
                0: do_read(rnd_word(), $urandom_range(0, 9), 4'($urandom));
                1: do_write(rnd_word(), $urandom_range(0, 9), 4'($urandom), 1'($urandom));
                default: fork
                    do_read(rnd_word(), $urandom_range(0, 9), 4'($urandom));
                    do_write(rnd_word(), $urandom_range(0, 9), 4'($urandom), 1'($urandom));
                join
            endcase
        end
        rmode = 0;
        bmode = 0;

        // Reset during beat 2 of an 8-beat read.
        d0 = delivered;
        send_ar(25'h10, 7, 4'd8);
        for (int n = 0; n < 50; n++) begin
            if (delivered - d0 >= 2) break;
            @(posedge clock);
        end
        chk_eq("pre_reset_beats", 64'(delivered - d0 >= 2), 64'd1);
        #2 reset = 1'b1;
        exp_r.delete();
        repeat (3) begin
            @(negedge clock);
            chk_eq("rst_rvalid", 64'(rvalid), 64'd0);
            chk_eq("rst_R0_en", 64'(R0_en), 64'd0);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        do_read(25'h10, 0, 4'd11);
        chk_eq("post_reset_beats", 64'(delivered), 64'd1);

        chk_eq("left_r", 64'(exp_r.size()), 64'd0);
        chk_eq("left_w", 64'(exp_w.size()), 64'd0);
        chk_eq("left_b", 64'(exp_b.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi4_sram_bridge.md
# axi4_sram_bridge

AXI4 slave that fronts the dual-port behavioural/synthesised SRAM macros (`mem_ext`, 25-bit word address; `mem_0_ext`, 9-bit word address) and converts AXI4 read/write bursts into the macros' W0 (masked write) and R0 (1-cycle-latency read) port accesses. It sits directly upstream of the SRAM, between the rocket-chip memory/MMIO AXI4 port and the array. It serialises reads and writes, absorbs R-channel backpressure, and sustains one beat per cycle in both directions.

## Interface
Parameters:
- ADDR_BITS, 25, SRAM word-address width (9 for the MMIO instance); AXI byte address is ADDR_BITS+3 bits.
- ID_BITS, 4, AXI ID width.

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  sole clock; also drives W0_clk and R0_clk.
- reset  in  1  asynchronous, active-high.
- awvalid/awready  in/out  1  AW handshake.
- awaddr  in  ADDR_BITS+3  burst start byte address.
- awlen  in  8  beats−1.   awid  in  ID_BITS.
- wvalid/wready  in/out  1.   wdata  in  64.   wstrb  in  8.   wlast  in  1.
- bvalid/bready  out/in  1.   bid  out  ID_BITS.   bresp  out  2  always 2'b00.
- arvalid/arready  in/out  1.   araddr  in  ADDR_BITS+3.   arlen  in  8.   arid  in  ID_BITS.
- rvalid/rready  out/in  1.   rdata  out  64.   rid  out  ID_BITS.   rresp  out  2  always 2'b00.   rlast  out  1.
- W0_clk, W0_addr[ADDR_BITS], W0_en, W0_data[64], W0_mask[8]  out  SRAM write port.
- R0_clk, R0_addr[ADDR_BITS], R0_en  out; R0_data  in  64  SRAM read port.

## Operation
- States: IDLE, READ, WRITE, WRESP.
- IDLE: arready/awready asserted only for the selected request. Both valid → round-robin; priority pointer resets to read, flips after each granted burst. Accept latches id, len, word address = addr[ADDR_BITS+2:3] (addr[2:0] ignored). awsize/arsize/burst type not present; every burst is INCR of 64-bit beats.
- READ: issue R0_en with R0_addr = current word address while issued < len+1 and (FIFO occupancy + in-flight − dequeue-this-cycle) ≤ 1. The data returned one cycle later is pushed into a 2-entry R FIFO; FIFO head drives rdata/rid/rlast. rlast set on beat len. Return to IDLE on handshake of the rlast beat.
- WRITE: wready = 1. Each w handshake drives W0_en = 1, W0_addr = current word address, W0_data = wdata, W0_mask = wstrb combinationally in the same cycle. After handshake of beat len, go to WRESP. wlast is not used for termination; a mismatch between wlast and the beat count is ignored.
- WRESP: bvalid = 1, bid = latched id; on bready go to IDLE.
- Word address increments by 1 per beat, modulo 2^ADDR_BITS (wraps 0x1FFFFFF → 0 in the 25-bit instance).
- R0_en/W0_en never asserted outside READ/WRITE; both are never asserted in the same cycle.

## Timing
- Reset values: all *ready, rvalid, bvalid, W0_en, R0_en = 0; rlast = 0; rid/bid/rdata = 0; state IDLE; FIFO empty; priority = read.
- Reset mid-burst: immediate abort, FIFO cleared, in-flight read discarded, no further SRAM enables; no B/R response emitted for the aborted burst.
- Read: ar handshake cycle T → R0_en at T+1 → rvalid at T+2. With rready held high, beats return back-to-back; a len=0 read completes (rvalid and rlast high) at T+2.
- rvalid, once asserted, holds with stable rdata/rlast until rready (AXI rule). rready low for any number of cycles loses no data: issue stalls at ≤2 outstanding entries.
- Write: aw handshake T → wready at T+1; bvalid the cycle after the final w handshake.
- Next AR/AW can be accepted the cycle after returning to IDLE (one bubble per burst).

## Test plan
- Single write awaddr=0x40, awlen=0, wdata=0x1122334455667788, wstrb=0x0F → W0_en one cycle, W0_addr=8, W0_mask=0x0F; bvalid next cycle, bresp=0, bid matches.
- Read araddr=0x40, arlen=3, rready=1 → R0_addr 8,9,10,11 on consecutive cycles; rvalid at T+2..T+5; rlast only on beat 3; rid matches arid.
- Same read with rready toggling 1-0-0-1 → four beats delivered in order, none dropped or duplicated, rdata stable while stalled, ≤2 outstanding.
- AW and AR asserted together from reset → read granted first, then write; next simultaneous pair → write granted first.
- 25-bit instance write burst at word 0x1FFFFFE, awlen=2 → W0_addr 0x1FFFFFE, 0x1FFFFFF, 0x0000000.
- Reset asserted during beat 2 of an 8-beat read → rvalid/R0_en fall low; after release, a fresh len=0 read returns correct data with rlast=1.
